// File: rtl/kosei_audio_pkg.sv
// Shared audio definitions: PCM sample width, stereo frame layout and small helpers.
package kosei_audio_pkg;

    localparam int unsigned PcmWidth   = 24;
    localparam int unsigned FrameWidth = 2 * PcmWidth;

    // One stereo frame; left occupies the upper half of the packed vector.
    typedef struct packed {
        logic [PcmWidth-1:0] left;
        logic [PcmWidth-1:0] right;
    } stereo_frame_t;

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/i2s_frame_ram.sv
// DEPTH x 48 frame storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the FIFO pointers.
module i2s_frame_ram
    import kosei_audio_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       bclk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [FrameWidth-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [FrameWidth-1:0]      rdata
);

    logic [FrameWidth-1:0] mem [DEPTH];

    // Write port: capture the frame on the rising edge when enabled.
    always_ff @(posedge bclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: combinational so the FIFO head is visible without a cycle of delay.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/i2s_frame_fifo.sv
// Show-ahead FIFO of stereo I2S frames with drop-on-full and a sticky, counted overflow.
module i2s_frame_fifo
    import kosei_audio_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                      bclk,
    input  logic                      rst_n,
    input  logic [PcmWidth-1:0]       in_l,
    input  logic [PcmWidth-1:0]       in_r,
    input  logic                      in_valid,
    output logic [PcmWidth-1:0]       out_l,
    output logic [PcmWidth-1:0]       out_r,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [7:0]                ovf_count,
    input  logic                      clr_ovf
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      ovf_count_q, ovf_count_d;

    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    stereo_frame_t   wr_frame;
    stereo_frame_t   head;
    logic [FrameWidth-1:0] head_raw;

    // Status and handshake decode from the current pointers.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
        pop   = !empty && out_ready;
        // A pop on the same edge frees the slot, so a full FIFO can still accept.
        push  = in_valid && (!full || pop);
        drop  = in_valid && full && !pop;
    end

    // Next-state for pointers and overflow bookkeeping.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        ovf_count_d = ovf_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        // A drop on the clearing edge wins: the clear is applied first, then the drop counts.
        if (drop) begin
            overflow_d  = 1'b1;
            ovf_count_d = clr_ovf ? 8'd1 : sat_inc8(ovf_count_q);
        end else if (clr_ovf) begin
            overflow_d  = 1'b0;
            ovf_count_d = 8'd0;
        end
    end

    // State registers; reset empties the FIFO without touching storage.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            ovf_count_q <= 8'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    // Pack the incoming samples into one frame word.
    always_comb begin
        wr_frame.left  = in_l;
        wr_frame.right = in_r;
    end

    i2s_frame_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .bclk  (bclk),
        .we    (push),
        .waddr (wr_ptr_q[AddrW-1:0]),
        .wdata (wr_frame),
        .raddr (rd_ptr_q[AddrW-1:0]),
        .rdata (head_raw)
    );

    // Outputs: head frame gated to zero when empty so stale storage never leaks out.
    always_comb begin
        head      = stereo_frame_t'(head_raw);
        out_valid = !empty;
        out_l     = out_valid ? head.left  : '0;
        out_r     = out_valid ? head.right : '0;
        level     = wr_ptr_q - rd_ptr_q;
        overflow  = overflow_q;
        ovf_count = ovf_count_q;
    end

endmodule

// File: tb/tb_i2s_frame_fifo.sv
// Self-checking bench for i2s_frame_fifo: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_i2s_frame_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          bclk = 1'b0;
    logic          rst_n;
    logic [23:0]   in_l, in_r;
    logic          in_valid;
    logic [23:0]   out_l, out_r;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          overflow;
    logic [7:0]    ovf_count;
    logic          clr_ovf;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain queues of samples plus the overflow bookkeeping.
    logic [23:0] mq_l[$];
    logic [23:0] mq_r[$];
    logic        m_ovf;
    int          m_cnt;
    logic [23:0] dut_pops[$];
    int          max_level;

    i2s_frame_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .bclk      (bclk),
        .rst_n     (rst_n),
        .in_l      (in_l),
        .in_r      (in_r),
        .in_valid  (in_valid),
        .out_l     (out_l),
        .out_r     (out_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .ovf_count (ovf_count),
        .clr_ovf   (clr_ovf)
    );

    always #5 bclk = ~bclk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq_l.delete();
        mq_r.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    // Apply one rising edge of the rules to the model using the current inputs.
    task automatic model_edge();
        bit popped, acc, drop;
        popped = (mq_l.size() > 0) && out_ready;
        acc    = in_valid && ((mq_l.size() < DEPTH) || popped);
        drop   = in_valid && !acc;
        if (popped) begin
            void'(mq_l.pop_front());
            void'(mq_r.pop_front());
        end
        if (acc) begin
            mq_l.push_back(in_l);
            mq_r.push_back(in_r);
        end
        if (drop) begin
            m_ovf = 1'b1;
            m_cnt = clr_ovf ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (clr_ovf) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
    endtask

    task automatic chk_model(input string name);
        logic        ev;
        logic [23:0] el, er;
        ev = (mq_l.size() > 0);
        el = ev ? mq_l[0] : 24'd0;
        er = ev ? mq_r[0] : 24'd0;
        chk(name, {out_valid, out_l, out_r, level, overflow, ovf_count},
            {ev, el, er, LW'(mq_l.size()), m_ovf, 8'(m_cnt)});
    endtask

    // One clock: record what the DUT hands over, update model, sample after the edge.
    task automatic tick(input string name);
        if (out_valid && out_ready) dut_pops.push_back(out_l);
        model_edge();
        @(posedge bclk);
        #1;
        if (int'(level) > max_level) max_level = int'(level);
        chk_model(name);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_l      = '0;
        in_r      = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("reset_state", {out_valid, out_l, out_r, level, overflow, ovf_count}, '0);
        @(negedge bclk);
        rst_n = 1'b1;
        dut_pops.delete();
        max_level = 0;
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r, input logic rdy,
                        input string name);
        in_valid  = 1'b1;
        in_l      = l;
        in_r      = r;
        out_ready = rdy;
        tick(name);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int k = 0; k < 4 * DEPTH && out_valid; k++) tick(name);
        out_ready = 1'b0;
        chk({name, "_empty"}, {31'd0, out_valid}, 32'd0);
    endtask

    typedef struct {
        logic        iv;
        logic [23:0] il;
        logic [23:0] ir;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [23:0] el;
        logic [23:0] er;
        logic [3:0]  elev;
        logic        eovf;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Directed vectors from an empty FIFO; the first one also proves the write on the
        // first edge after reset release and one-cycle latency.
        vecs[0] = '{1'b1, 24'h123456, 24'hABCDEF, 1'b0, 1'b0,
                    1'b1, 24'h123456, 24'hABCDEF, 4'd1, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 24'h000001, 24'h000002, 1'b1, 1'b0,
                    1'b1, 24'h000001, 24'h000002, 4'd1, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 24'h0, 24'h0, 1'b0, 1'b0,
                    1'b1, 24'h000001, 24'h000002, 4'd1, 1'b0, 8'd0};
        vecs[3] = '{1'b1, 24'h000003, 24'h000004, 1'b0, 1'b0,
                    1'b1, 24'h000001, 24'h000002, 4'd2, 1'b0, 8'd0};
        vecs[4] = '{1'b0, 24'h0, 24'h0, 1'b1, 1'b0,
                    1'b1, 24'h000003, 24'h000004, 4'd1, 1'b0, 8'd0};
        vecs[5] = '{1'b0, 24'h0, 24'h0, 1'b1, 1'b0,
                    1'b0, 24'h0, 24'h0, 4'd0, 1'b0, 8'd0};
        vecs[6] = '{1'b1, 24'hFFFFFF, 24'h800000, 1'b1, 1'b0,
                    1'b1, 24'hFFFFFF, 24'h800000, 4'd1, 1'b0, 8'd0};
        vecs[7] = '{1'b0, 24'h0, 24'h0, 1'b1, 1'b1,
                    1'b0, 24'h0, 24'h0, 4'd0, 1'b0, 8'd0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid  = vecs[i].iv;
            in_l      = vecs[i].il;
            in_r      = vecs[i].ir;
            out_ready = vecs[i].rdy;
            clr_ovf   = vecs[i].clr;
            tick($sformatf("vec%0d_model", i));
            chk($sformatf("vec%0d", i),
                {out_valid, out_l, out_r, level, overflow, ovf_count},
                {vecs[i].ev, vecs[i].el, vecs[i].er, vecs[i].elev, vecs[i].eovf, vecs[i].ecnt});
        end
        idle_inputs();

        // Fill/wrap: 20 frames, consumer ready every other cycle, producer skips 1 in 4.
        do_reset();
        begin
            int n = 0;
            for (int c = 0; c < 200 && n < 20; c++) begin
                out_ready = c[0];
                in_valid  = (c % 4 != 3);
                in_l      = 24'(n);
                in_r      = ~24'(n);
                if (in_valid) n++;
                tick("wrap");
            end
        end
        in_valid = 1'b0;
        drain("wrap_drain");
        chk("wrap_count", 32'(dut_pops.size()), 32'd20);
        for (int i = 0; i < 20 && i < dut_pops.size(); i++)
            chk($sformatf("wrap_order%0d", i), {104'd0, dut_pops[i]}, 128'(i));
        chk("wrap_maxlevel", 32'(max_level <= DEPTH), 32'd1);
        chk("wrap_noovf", {127'd0, overflow}, 128'd0);

        // Overflow: 11 pushes into DEPTH=8 with the consumer stalled.
        do_reset();
        for (int i = 0; i < 11; i++) push(24'(i), 24'(i + 100), 1'b0, "ovf_fill");
        chk("ovf_state", {level, overflow, ovf_count}, {4'd8, 1'b1, 8'd3});
        drain("ovf_drain");
        chk("ovf_pops", 32'(dut_pops.size()), 32'd8);
        for (int i = 0; i < 8 && i < dut_pops.size(); i++)
            chk($sformatf("ovf_order%0d", i), {104'd0, dut_pops[i]}, 128'(i));

        // Full with simultaneous pop: accepted, no overflow, new frame last.
        do_reset();
        for (int i = 0; i < 8; i++) push(24'(i), 24'(i), 1'b0, "fwp_fill");
        push(24'hAAAAAA, 24'h555555, 1'b1, "fwp_push");
        chk("fwp_state", {level, overflow}, {4'd8, 1'b0});
        drain("fwp_drain");
        chk("fwp_pops", 32'(dut_pops.size()), 32'd9);
        if (dut_pops.size() == 9) chk("fwp_last", {104'd0, dut_pops[8]}, {104'd0, 24'hAAAAAA});

        // Saturation and clear priority.
        do_reset();
        for (int i = 0; i < 8; i++) push(24'(i), 24'(i), 1'b0, "sat_fill");
        for (int i = 0; i < 260; i++) push(24'hDEAD00, 24'h0, 1'b0, "sat_drop");
        chk("sat_cnt", {overflow, ovf_count}, {1'b1, 8'd255});
        clr_ovf = 1'b1;
        tick("clr_nodrop");
        chk("clr_nodrop_val", {overflow, ovf_count}, {1'b0, 8'd0});
        in_valid = 1'b1;
        tick("clr_drop");
        chk("clr_drop_val", {overflow, ovf_count, level}, {1'b1, 8'd1, 4'd8});
        idle_inputs();

        // Mid-operation asynchronous reset, asserted between edges.
        do_reset();
        for (int i = 0; i < 5; i++) push(24'(i + 50), 24'(i), 1'b0, "mid_fill");
        chk("mid_level5", {28'd0, level}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_async", {out_valid, level, out_l}, '0);
        @(negedge bclk);
        rst_n = 1'b1;
        push(24'h0BEEF0, 24'h0CAFE0, 1'b0, "mid_first");
        chk("mid_first_head", {out_valid, out_l, out_r, level},
            {1'b1, 24'h0BEEF0, 24'h0CAFE0, 4'd1});

        // Randomized traffic against the model, in phases of differing consumer speed.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_l      = 24'($urandom);
            in_r      = 24'($urandom);
            out_ready = ($urandom_range(0, 99) < ((c < 300) ? 30 : 75));
            clr_ovf   = ($urandom_range(0, 99) < 4);
            tick("rand");
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_frame_fifo.md
I2S_FRAME_FIFO -- requirements
Module: i2s_frame_fifo

Interface
REQ-001 SHALL have parameter: DEPTH, 8, number of stereo frames stored; power of two, minimum 2.
REQ-002 SHALL have port: bclk  input  1  sole clock, I2S bit clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_l  input  24  left PCM sample from the I2S receiver, two's complement.
REQ-005 SHALL have port: in_r  input  24  right PCM sample from the I2S receiver, two's complement.
REQ-006 SHALL have port: in_valid  input  1  one-cycle pulse marking in_l/in_r as a complete frame; no backpressure.
REQ-007 SHALL have port: out_l  output  24  left sample at FIFO head.
REQ-008 SHALL have port: out_r  output  24  right sample at FIFO head.
REQ-009 SHALL have port: out_valid  output  1  head frame present.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the head frame.
REQ-011 SHALL have port: level  output  $clog2(DEPTH)+1  frames currently stored, 0..DEPTH.
REQ-012 SHALL have port: overflow  output  1  sticky flag: a frame was dropped.
REQ-013 SHALL have port: ovf_count  output  8  count of dropped frames, saturating at 255.
REQ-014 SHALL have port: clr_ovf  input  1  synchronous clear of overflow and ovf_count.

Function
REQ-015 SHALL store in_l/in_r as one 48-bit frame, written at the rising edge where in_valid=1 and the frame is accepted.
REQ-016 SHALL be show-ahead: out_valid = (level != 0), out_l/out_r reflect the head entry combinationally from storage.
REQ-017 SHALL drive out_l/out_r to 0 whenever out_valid=0.
REQ-018 SHALL have latency 1: a frame written into an empty FIFO at edge N gives out_valid=1 after edge N.
REQ-019 SHALL pop the head on an edge where out_valid=1 and out_ready=1; out_ready is ignored when out_valid=0.
REQ-020 SHALL accept a write when level<DEPTH, or when level=DEPTH and a pop occurs on the same edge.
REQ-021 SHALL, on simultaneous accepted push and pop, leave level unchanged and advance both pointers.
REQ-022 SHALL, on in_valid=1 with level=DEPTH and no pop, drop the incoming frame, keep stored contents, set overflow, increment ovf_count unless at 255.
REQ-023 SHALL use read/write pointers of $clog2(DEPTH)+1 bits wrapping modulo 2*DEPTH; full = equal index with differing MSB, empty = pointers equal.
REQ-024 SHALL, on clr_ovf=1 without a drop that edge, clear overflow to 0 and ovf_count to 0.
REQ-025 SHALL, on clr_ovf=1 with a drop the same edge, give overflow=1 and ovf_count=1.
REQ-026 SHALL preserve frame order exactly; no frame is duplicated or reordered.

Reset
REQ-027 SHALL, while rst_n=0, force pointers to 0, level=0, out_valid=0, out_l=out_r=0, overflow=0, ovf_count=0, independent of bclk.
REQ-028 SHALL discard all stored frames on reset asserted mid-operation; storage contents need no reset.
REQ-029 SHALL accept a write on the first rising bclk edge after rst_n deassertion.

Structure
REQ-030 SHALL take PCM width (24) and the stereo frame typedef {left, right} from shared package kosei_audio_pkg.
REQ-031 SHALL instantiate one sub-module i2s_frame_ram: DEPTH x 48 storage, one synchronous write port, one asynchronous read port.
REQ-032 SHALL keep pointer, level and overflow logic in i2s_frame_fifo.

Verification
REQ-033 SHALL cover basic: reset, push L=24'h123456 R=24'hABCDEF, out_ready=0 -> next cycle out_valid=1, out_l=24'h123456, out_r=24'hABCDEF, level=1.
REQ-034 SHALL cover fill/wrap: push 20 frames (L=i, R=~i) with out_ready=1 every other cycle -> output order 0..19, level never >DEPTH, no overflow.
REQ-035 SHALL cover overflow: out_ready=0, push 11 frames (DEPTH=8) -> level=8, overflow=1, ovf_count=3, popped frames 0..7 only.
REQ-036 SHALL cover full-with-pop: level=8, in_valid=1 and out_ready=1 same edge -> level stays 8, overflow stays 0, new frame appears last.
REQ-037 SHALL cover clear/saturation: 260 drops -> ovf_count=255; clr_ovf with no drop -> 0/0; clr_ovf with drop same edge -> overflow=1, ovf_count=1.
REQ-038 SHALL cover mid-operation reset: level=5, assert rst_n=0 between edges -> out_valid=0, level=0 immediately; after release first push is first output.
